l1c_inst_assoc: RTL and testbench
=================================

Name: l1c_inst_assoc

Overview:
Parametrised successor to the direct-mapped L1 instruction cache: a read-allocate instruction cache with configurable sets, ways (1 or 2) and multi-word lines. Sits between the CPU core fetch port and the CPU-wrapper memory port. Adds burst line refill, LRU replacement, write pass-through with line invalidation, a global flush, and hit/miss counters. Tag, data and valid storage are internal flops; no SRAM macros.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, word width
SETS, 16, number of sets (power of 2, >=2)
WAYS, 2, associativity; legal values 1 or 2
LINE_WORDS, 4, words per line (power of 2, >=2)
TYPE_W, 3, width of access-type field
TYPE_WORD, 3'b010, access type driven on I_type for refill reads
CNT_W, 32, hit/miss counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
core_addr  in  ADDR_W  byte address, held stable while core_req=1 and core_wait=1
core_req  in  1  core request
core_write  in  1  1 = write (pass-through), 0 = fetch
core_in  in  DATA_W  write data
core_type  in  TYPE_W  access type for writes
flush  in  1  single-cycle pulse; invalidate all lines
I_out  in  DATA_W  memory read data, valid when I_req=1 and I_wait=0
I_wait  in  1  memory busy; a transfer completes in a cycle with I_req=1 and I_wait=0
core_out  out  DATA_W  fetched word, valid when core_req=1 and core_wait=0
core_wait  out  1  stall to core
I_req  out  1  memory request
I_addr  out  ADDR_W  memory word address
I_write  out  1  memory write
I_in  out  DATA_W  memory write data
I_type  out  TYPE_W  memory access type
hit_cnt  out  CNT_W  fetch hits since reset (wraps)
miss_cnt  out  CNT_W  fetch misses since reset (wraps)

Behaviour:
- Address split: offset = addr[1:0] (ignored); word = next log2(LINE_WORDS) bits; index = next log2(SETS) bits; tag = remaining upper bits.
- Reset (async): state IDLE; all valid bits, LRU bits, counters, flush-pending cleared; all outputs 0. Reset mid-refill abandons the line (stays invalid); I_req drops immediately.
- core_wait = core_req AND NOT (response cycle). Exactly one cycle with core_wait=0 per request.
- States: IDLE, LOOKUP, REFILL, RESP, WRITE.
- IDLE: if flush or flush-pending, clear all valid bits this cycle, clear pending, ignore core_req this cycle. Else if core_req: latch address/data/type/write, go to LOOKUP (fetch) or WRITE (write).
- LOOKUP: compare latched tag against valid ways of the set. Hit: core_out = hit word, core_wait=0, hit_cnt+1, LRU set to the other way, back to IDLE. Hit latency: response in the 2nd cycle of the request. Miss: miss_cnt+1, choose victim (first invalid way, way0 before way1; else LRU way; WAYS=1 always way0), clear victim valid, go to REFILL with beat counter 0.
- REFILL: I_req=1, I_write=0, I_type=TYPE_WORD, I_addr = {tag,index,beat,2'b00}, incrementing from the line base (word 0) regardless of requested word. On each completed beat, store I_out into victim way at word=beat, beat+1. After beat LINE_WORDS-1 completes: write tag, set valid, LRU to the other way, go to RESP. I_req stays high across beats until the last beat completes.
- RESP: core_out = filled word at requested offset, core_wait=0, to IDLE.
- WRITE: I_req=1, I_write=1, I_addr = latched address, I_in = core_in, I_type = core_type. On completion: core_wait=0, go to IDLE; any way whose tag matches the latched address is invalidated in the same cycle. Counters unchanged.
- flush outside IDLE: set flush-pending; applied on next IDLE cycle before any new request. An in-progress refill still completes and its response is still returned, then the line is flushed.
- flush and core_req both in IDLE: flush wins; request is accepted the following cycle (core_wait stays 1).
- core_out holds its last value outside response cycles.

Test Plan:
- Cold fetch 0x0000_0104 (SETS=16, LINE_WORDS=4): four I_req beats at 0x100, 0x104, 0x108, 0x10C with I_out = 0xA0..0xA3 -> core_out=0xA1, miss_cnt=1; refetch 0x108 -> core_wait low in 2nd cycle, core_out=0xA2, hit_cnt=1, no I_req.
- WAYS=2 conflict: fill 0x0000, 0x1000, 0x2000 (same set), touching 0x0000 before 0x2000 -> 0x1000 evicted; refetch 0x0000 hits, 0x1000 misses.
- I_wait held high for 3 cycles on beat 2 -> I_addr stable, I_req held, core_wait stays 1, correct data returned.
- Write 0x0000_0104 after caching its line -> one I_write=1 beat with I_in=core_in; next fetch 0x0100 misses and refills.
- flush pulsed during REFILL -> pending response delivered; next fetch to the same line misses; flush with core_req in IDLE delays acceptance one cycle.
- rst asserted mid-REFILL -> I_req=0 and counters=0 immediately; refetch of the same line misses.

Source files
------------

// File: rtl/l1c_inst_assoc.sv
// rtl/l1c_inst_assoc.sv - set-associative read-allocate L1 instruction cache
// Burst line refill, LRU replacement, write pass-through with invalidation, flush, hit/miss counters.
module l1c_inst_assoc #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                SETS       = 16,
  parameter int                WAYS       = 2,
  parameter int                LINE_WORDS = 4,
  parameter int                TYPE_W     = 3,
  parameter logic [TYPE_W-1:0] TYPE_WORD  = 3'b010,
  parameter int                CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_req,
  input  logic              core_write,
  input  logic [DATA_W-1:0] core_in,
  input  logic [TYPE_W-1:0] core_type,
  input  logic              flush,
  input  logic [DATA_W-1:0] I_out,
  input  logic              I_wait,
  output logic [DATA_W-1:0] core_out,
  output logic              core_wait,
  output logic              I_req,
  output logic [ADDR_W-1:0] I_addr,
  output logic              I_write,
  output logic [DATA_W-1:0] I_in,
  output logic [TYPE_W-1:0] I_type,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int WORD_B = $clog2(LINE_WORDS);
  localparam int IDX_B  = $clog2(SETS);
  localparam int TAG_B  = ADDR_W - 2 - WORD_B - IDX_B;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESP, WRITE} state_t;
  state_t state, state_n;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, out_q;
  logic [TYPE_W-1:0] type_q;
  logic [WORD_B-1:0] beat;
  logic              victim, flush_pend;

  logic              valid [WAYS][SETS];
  logic              lru   [SETS];
  logic [TAG_B-1:0]  tags  [WAYS][SETS];
  logic [DATA_W-1:0] mem   [WAYS][SETS][LINE_WORDS];

  logic [WORD_B-1:0] word_q;
  logic [IDX_B-1:0]  idx_q;
  logic [TAG_B-1:0]  tag_q;
  assign word_q = addr_q[2 +: WORD_B];
  assign idx_q  = addr_q[2+WORD_B +: IDX_B];
  assign tag_q  = addr_q[ADDR_W-1 -: TAG_B];

  logic flush_now, accept, beat_done, last_beat, hit, hit_way, victim_c, resp;
  logic [WAYS-1:0] tag_match;

  // A pending or fresh flush owns the IDLE cycle; the request waits one more cycle.
  assign flush_now = (state == IDLE) && (flush || flush_pend);
  assign accept    = (state == IDLE) && !(flush || flush_pend) && core_req;
  assign beat_done = (state == REFILL) && !I_wait;
  assign last_beat = (beat == WORD_B'(LINE_WORDS - 1));

  always_comb begin
    hit       = 1'b0;
    hit_way   = 1'b0;
    tag_match = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][idx_q] && tags[w][idx_q] == tag_q) begin
        tag_match[w] = 1'b1;
        hit          = 1'b1;
        hit_way      = 1'(w);
      end
    end
    // Lowest-numbered invalid way wins over the LRU choice.
    victim_c = (WAYS > 1) ? lru[idx_q] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][idx_q]) victim_c = 1'(w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = core_write ? WRITE : LOOKUP;
      LOOKUP:  state_n = hit ? IDLE : REFILL;
      REFILL:  if (beat_done && last_beat) state_n = RESP;
      RESP:    state_n = IDLE;
      WRITE:   if (!I_wait) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    resp     = 1'b0;
    core_out = out_q;
    I_req    = 1'b0;
    I_write  = 1'b0;
    I_addr   = '0;
    I_in     = '0;
    I_type   = '0;
    case (state)
      LOOKUP: begin
        if (hit) begin
          resp     = 1'b1;
          core_out = mem[hit_way][idx_q][word_q];
        end
      end
      REFILL: begin
        I_req  = 1'b1;
        I_type = TYPE_WORD;
        I_addr = {tag_q, idx_q, beat, 2'b00};
      end
      RESP: begin
        resp     = 1'b1;
        core_out = mem[victim][idx_q][word_q];
      end
      WRITE: begin
        I_req   = 1'b1;
        I_write = 1'b1;
        I_addr  = addr_q;
        I_in    = data_q;
        I_type  = type_q;
        resp    = !I_wait;
      end
      default: ;
    endcase
  end

  assign core_wait = core_req && !resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      data_q     <= '0;
      type_q     <= '0;
      out_q      <= '0;
      beat       <= '0;
      victim     <= 1'b0;
      flush_pend <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        lru[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) valid[w][s] <= 1'b0;
      end
    end else begin
      if (resp) out_q <= core_out;
      if (flush_now) begin
        flush_pend <= 1'b0;
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) valid[w][s] <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
      if (accept) begin
        addr_q <= core_addr;
        data_q <= core_in;
        type_q <= core_type;
      end
      case (state)
        LOOKUP: begin
          if (hit) begin
            hit_cnt    <= hit_cnt + CNT_W'(1);
            lru[idx_q] <= ~hit_way;
          end else begin
            miss_cnt                <= miss_cnt + CNT_W'(1);
            victim                  <= victim_c;
            valid[victim_c][idx_q]  <= 1'b0;
            beat                    <= '0;
          end
        end
        REFILL: begin
          if (!I_wait) begin
            beat <= beat + WORD_B'(1);
            if (last_beat) begin
              valid[victim][idx_q] <= 1'b1;
              lru[idx_q]           <= ~victim;
            end
          end
        end
        WRITE: begin
          if (!I_wait) begin
            for (int w = 0; w < WAYS; w++)
              if (tag_match[w]) valid[w][idx_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; valid bits alone decide what is usable.
  always_ff @(posedge clk) begin
    if (beat_done) begin
      mem[victim][idx_q][beat] <= I_out;
      if (last_beat) tags[victim][idx_q] <= tag_q;
    end
  end
endmodule

// File: tb/tb_l1c_inst_assoc.sv
// tb/tb_l1c_inst_assoc.sv - directed self-checking bench for l1c_inst_assoc
module tb_l1c_inst_assoc;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_addr;
  logic        core_req, core_write;
  logic [31:0] core_in;
  logic [2:0]  core_type;
  logic        flush;
  logic [31:0] I_out;
  logic        I_wait;
  logic [31:0] core_out;
  logic        core_wait;
  logic        I_req;
  logic [31:0] I_addr;
  logic        I_write;
  logic [31:0] I_in;
  logic [2:0]  I_type;
  logic [31:0] hit_cnt, miss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  l1c_inst_assoc dut (
    .clk(clk), .rst(rst), .core_addr(core_addr), .core_req(core_req), .core_write(core_write),
    .core_in(core_in), .core_type(core_type), .flush(flush), .I_out(I_out), .I_wait(I_wait),
    .core_out(core_out), .core_wait(core_wait), .I_req(I_req), .I_addr(I_addr), .I_write(I_write),
    .I_in(I_in), .I_type(I_type), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Backing memory: word at byte address a holds (a >> 2) + 0x60, so 0x100..0x10C -> 0xA0..0xA3.
  always_comb I_out = (I_addr >> 2) + 32'h60;

  task automatic do_fetch(input logic [31:0] a, input int stall_from, input int stall_len, input int flush_cyc,
                          output int lat, output logic [31:0] dout, output int beats,
                          output int addr_err, output int stalls, output int stall_err);
    logic [31:0] base;
    bit done;
    int cyc;
    base = {a[31:4], 4'h0};
    lat = -1; dout = '0; beats = 0; addr_err = 0; stalls = 0; stall_err = 0; done = 0;
    @(posedge clk); #1;
    core_addr = a; core_write = 1'b0; core_req = 1'b1; cyc = 1;
    I_wait = (cyc >= stall_from) && (cyc < stall_from + stall_len);
    flush  = (cyc == flush_cyc);
    while (!done && cyc <= 80) begin
      @(negedge clk);
      if (I_req && I_wait) begin
        stalls++;
        if (I_addr !== base + 32'(4 * beats) || core_wait !== 1'b1) stall_err++;
      end
      if (I_req && !I_wait) begin
        if (I_addr !== base + 32'(4 * beats) || I_write !== 1'b0 || I_type !== 3'b010) addr_err++;
        beats++;
      end
      if (!core_wait) begin
        done = 1; lat = cyc; dout = core_out;
      end
      @(posedge clk); #1;
      cyc++;
      I_wait = (cyc >= stall_from) && (cyc < stall_from + stall_len);
      flush  = (cyc == flush_cyc);
    end
    core_req = 1'b0; I_wait = 1'b0; flush = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                          output int lat, output int wr_beats, output int wr_err);
    bit done;
    int cyc;
    lat = -1; wr_beats = 0; wr_err = 0; done = 0;
    @(posedge clk); #1;
    core_addr = a; core_in = d; core_type = t; core_write = 1'b1; core_req = 1'b1; cyc = 1;
    while (!done && cyc <= 40) begin
      @(negedge clk);
      if (I_req) begin
        if (I_write !== 1'b1 || I_addr !== a || I_in !== d || I_type !== t) wr_err++;
        if (!I_wait) wr_beats++;
      end
      if (!core_wait) begin
        done = 1; lat = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    core_req = 1'b0; core_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (I_req !== 1'b0) begin n_bad++; $display("FAIL reset_i_req: got %b want 0", I_req); end
    n_cmp++; if (core_wait !== 1'b0) begin n_bad++; $display("FAIL reset_core_wait: got %b want 0", core_wait); end
    n_cmp++; if (core_out !== 32'h0) begin n_bad++; $display("FAIL reset_core_out: got %h want 0", core_out); end
    n_cmp++; if (hit_cnt !== 32'h0) begin n_bad++; $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt); end
    n_cmp++; if (miss_cnt !== 32'h0) begin n_bad++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (I_req !== 1'b0 || I_write !== 1'b0) begin n_bad++; $display("FAIL idle_i_req: got %b/%b want 0/0", I_req, I_write); end
  endtask

  task automatic test_cold_fetch();
    int lat, beats, aerr, st, serr;
    logic [31:0] d;
    do_fetch(32'h104, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (d !== 32'hA1) begin n_bad++; $display("FAIL cold_data: got %h want a1", d); end
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL cold_latency: got %0d want 7", lat); end
    n_cmp++; if (beats !== 4) begin n_bad++; $display("FAIL cold_beats: got %0d want 4", beats); end
    n_cmp++; if (aerr !== 0) begin n_bad++; $display("FAIL cold_beat_addr: got %0d bad beats want 0", aerr); end
    n_cmp++; if (miss_cnt !== 32'd1) begin n_bad++; $display("FAIL cold_miss_cnt: got %0d want 1", miss_cnt); end
    do_fetch(32'h108, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (d !== 32'hA2) begin n_bad++; $display("FAIL hit_data: got %h want a2", d); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL hit_latency: got %0d want 2", lat); end
    n_cmp++; if (beats !== 0) begin n_bad++; $display("FAIL hit_no_ireq: got %0d beats want 0", beats); end
    n_cmp++; if (hit_cnt !== 32'd1) begin n_bad++; $display("FAIL hit_cnt: got %0d want 1", hit_cnt); end
    n_cmp++; if (miss_cnt !== 32'd1) begin n_bad++; $display("FAIL hit_miss_cnt: got %0d want 1", miss_cnt); end
  endtask

  task automatic test_lru_conflict();
    int lat, beats, aerr, st, serr;
    logic [31:0] d, h0, m0;
    h0 = hit_cnt; m0 = miss_cnt;
    do_fetch(32'h0000, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (d !== 32'h60 || beats !== 4) begin n_bad++; $display("FAIL lru_fill0: got %h/%0d want 60/4", d, beats); end
    do_fetch(32'h1000, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (d !== 32'h460 || beats !== 4) begin n_bad++; $display("FAIL lru_fill1: got %h/%0d want 460/4", d, beats); end
    do_fetch(32'h0000, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (lat !== 2 || d !== 32'h60) begin n_bad++; $display("FAIL lru_touch0: got lat %0d data %h want 2/60", lat, d); end
    do_fetch(32'h2000, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (d !== 32'h860 || beats !== 4) begin n_bad++; $display("FAIL lru_fill2: got %h/%0d want 860/4", d, beats); end
    do_fetch(32'h0000, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (lat !== 2 || beats !== 0) begin n_bad++; $display("FAIL lru_keep0: got lat %0d beats %0d want 2/0", lat, beats); end
    do_fetch(32'h1000, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (beats !== 4 || d !== 32'h460) begin n_bad++; $display("FAIL lru_evict1: got beats %0d data %h want 4/460", beats, d); end
    n_cmp++; if (hit_cnt - h0 !== 32'd2) begin n_bad++; $display("FAIL lru_hits: got %0d want 2", hit_cnt - h0); end
    n_cmp++; if (miss_cnt - m0 !== 32'd4) begin n_bad++; $display("FAIL lru_misses: got %0d want 4", miss_cnt - m0); end
  endtask

  task automatic test_stall();
    int lat, beats, aerr, st, serr;
    logic [31:0] d, m0;
    m0 = miss_cnt;
    do_fetch(32'h358, 5, 3, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (d !== 32'h136) begin n_bad++; $display("FAIL stall_data: got %h want 136", d); end
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL stall_latency: got %0d want 10", lat); end
    n_cmp++; if (st !== 3) begin n_bad++; $display("FAIL stall_cycles: got %0d want 3", st); end
    n_cmp++; if (serr !== 0) begin n_bad++; $display("FAIL stall_hold: got %0d unstable cycles want 0", serr); end
    n_cmp++; if (beats !== 4 || aerr !== 0) begin n_bad++; $display("FAIL stall_beats: got %0d beats %0d bad want 4/0", beats, aerr); end
    n_cmp++; if (miss_cnt - m0 !== 32'd1) begin n_bad++; $display("FAIL stall_miss: got %0d want 1", miss_cnt - m0); end
  endtask

  task automatic test_write_invalidate();
    int lat, beats, aerr, st, serr, wl, wb, we;
    logic [31:0] d, h0, m0;
    do_fetch(32'h100, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (d !== 32'hA0 || beats !== 4) begin n_bad++; $display("FAIL wr_prefill: got %h/%0d want a0/4", d, beats); end
    do_fetch(32'h104, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (lat !== 2 || d !== 32'hA1) begin n_bad++; $display("FAIL wr_cached: got lat %0d data %h want 2/a1", lat, d); end
    h0 = hit_cnt; m0 = miss_cnt;
    do_write(32'h104, 32'hDEAD_BEEF, 3'b001, wl, wb, we);
    n_cmp++; if (wl !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d want 2", wl); end
    n_cmp++; if (wb !== 1 || we !== 0) begin n_bad++; $display("FAIL wr_beat: got %0d beats %0d bad want 1/0", wb, we); end
    n_cmp++; if (hit_cnt !== h0 || miss_cnt !== m0) begin n_bad++; $display("FAIL wr_counters: got %0d/%0d want %0d/%0d", hit_cnt, miss_cnt, h0, m0); end
    do_fetch(32'h100, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (beats !== 4 || lat !== 7 || d !== 32'hA0) begin n_bad++; $display("FAIL wr_invalidated: got beats %0d lat %0d data %h want 4/7/a0", beats, lat, d); end
    do_fetch(32'h1000, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (lat !== 2 || d !== 32'h460) begin n_bad++; $display("FAIL wr_other_way: got lat %0d data %h want 2/460", lat, d); end
  endtask

  task automatic test_flush();
    int lat, beats, aerr, st, serr;
    logic [31:0] d;
    do_fetch(32'h464, 0, 0, 4, lat, d, beats, aerr, st, serr);
    n_cmp++; if (lat !== 7 || d !== 32'h179) begin n_bad++; $display("FAIL flush_resp: got lat %0d data %h want 7/179", lat, d); end
    do_fetch(32'h464, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (beats !== 4 || lat !== 7) begin n_bad++; $display("FAIL flush_miss: got beats %0d lat %0d want 4/7", beats, lat); end
    do_fetch(32'h468, 0, 0, 1, lat, d, beats, aerr, st, serr);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL flush_idle_delay: got %0d want 8", lat); end
    n_cmp++; if (beats !== 4 || d !== 32'h17A) begin n_bad++; $display("FAIL flush_idle_refill: got beats %0d data %h want 4/17a", beats, d); end
    do_fetch(32'h46C, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (lat !== 2 || d !== 32'h17B) begin n_bad++; $display("FAIL flush_refill_hit: got lat %0d data %h want 2/17b", lat, d); end
  endtask

  task automatic test_reset_mid_refill();
    int lat, beats, aerr, st, serr;
    logic [31:0] d;
    @(posedge clk); #1;
    core_addr = 32'h5A4; core_write = 1'b0; core_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++; if (I_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre_ireq: got %b want 1", I_req); end
    rst = 1'b1;
    #1;
    n_cmp++; if (I_req !== 1'b0) begin n_bad++; $display("FAIL rst_ireq_drop: got %b want 0", I_req); end
    n_cmp++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_counters: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    @(posedge clk); #1;
    rst = 1'b0; core_req = 1'b0;
    do_fetch(32'h5A4, 0, 0, 0, lat, d, beats, aerr, st, serr);
    n_cmp++; if (beats !== 4 || lat !== 7 || d !== 32'h1C9) begin n_bad++; $display("FAIL rst_refetch: got beats %0d lat %0d data %h want 4/7/1c9", beats, lat, d); end
    n_cmp++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_refetch_cnt: got %0d/%0d want 1/0", miss_cnt, hit_cnt); end
  endtask

  initial begin
    rst = 1'b1; core_addr = '0; core_req = 1'b0; core_write = 1'b0; core_in = '0;
    core_type = '0; flush = 1'b0; I_wait = 1'b0;
    test_reset();
    test_cold_fetch();
    test_lru_conflict();
    test_stall();
    test_write_invalidate();
    test_flush();
    test_reset_mid_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
